proto_frame_engine: RTL and testbench
=====================================

PROTO_FRAME_ENGINE -- requirements
Module: proto_frame_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width of the rx/tx data paths.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, payload buffer depth in words (2..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000, inter-word rx timeout in in_clk cycles.
REQ-004 The block SHALL have port in_clk, input, 1 bit: single clock; one clock; all logic on rising edge.
REQ-005 The block SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data_rx, input, DATA_W bits: received word.
REQ-007 The block SHALL have port in_data_rx_hsk_req, input, 1 bit: rx word valid request (4-phase).
REQ-008 The block SHALL have port out_data_rx_hsk_ack, output, 1 bit: rx acknowledge.
REQ-009 The block SHALL have port out_data_tx, output, DATA_W bits: transmitted word.
REQ-010 The block SHALL have port out_data_tx_hsk_req, output, 1 bit: tx word valid request (4-phase).
REQ-011 The block SHALL have port in_data_tx_hsk_ack, input, 1 bit: tx acknowledge.
REQ-012 The block SHALL have port out_rx_enable, output, 1 bit: high while a new rx word is accepted.
REQ-013 The block SHALL have port out_busy, output, 1 bit: high in every state except RX_CMD.
REQ-014 The block SHALL have port out_frame_err, output, 1 bit: 1-cycle pulse when a frame completes with status other than OK.

Function
REQ-015 The block SHALL receive frames as CMD, LEN, LEN payload words; LEN is the low 8 bits of the LEN word.
REQ-016 The block SHALL run the rx handshake in four phases: with out_rx_enable high, req high -> sample in_data_rx, ack high next cycle; ack held until req low; ack low the cycle after req low; next word accepted only after ack low.
REQ-017 The block SHALL run the tx handshake in four phases: word on out_data_tx, req high; ack high -> req low next cycle; next word after ack low; out_data_tx stable from req rise until ack fall.
REQ-018 The block SHALL implement states RX_CMD -> RX_LEN -> RX_PAY (skipped when LEN=0) -> [RX_CHK] -> EXEC -> TX -> RX_CMD.
REQ-019 The block SHALL store payload words at buffer index 0..LEN-1 when LEN<=MAX_LEN.
REQ-020 The block SHALL, when LEN>MAX_LEN, still handshake LEN payload words, discard them, and set status BAD_LEN.
REQ-021 The block SHALL decode commands in EXEC: 0x01 ECHO returns the stored payload unchanged; 0x02 SUM returns one word equal to the payload sum modulo 2^DATA_W (0 when LEN=0); other values give status BAD_CMD.
REQ-022 The block SHALL spend exactly one cycle in EXEC.
REQ-023 The block SHALL transmit the response as CMD, STATUS, RLEN, RLEN data words; RLEN is 0 for any non-OK status.
REQ-024 The block SHALL use status codes OK=0x00, BAD_CMD=0x01, BAD_LEN=0x02, TIMEOUT=0x03, BAD_CHK=0x04, zero-extended to DATA_W.
REQ-025 The block SHALL, in RX_LEN, RX_PAY or RX_CHK, count cycles with req low and ack low; on reaching TIMEOUT_CYC it SHALL abort to EXEC with status TIMEOUT. The count SHALL clear on every accepted word.
REQ-026 The block SHALL give the first failure detected priority when several apply: BAD_LEN over BAD_CHK, and TIMEOUT over all others.
REQ-027 The block SHALL hold out_rx_enable low from EXEC until the last tx ack falls; rx req during TX SHALL be ignored (no ack).
REQ-028 The block SHALL pulse out_frame_err in the cycle that leaves TX when STATUS != OK.

Reset
REQ-029 The block SHALL, on in_rst high at a clock edge, enter RX_CMD and drive out_data_rx_hsk_ack=0, out_data_tx_hsk_req=0, out_data_tx=0, out_rx_enable=1 (first cycle after reset), out_busy=0, out_frame_err=0, and clear the timeout counter and status.
REQ-030 The block SHALL abandon any frame or response in progress when reset is asserted mid-operation, without completing the handshake; buffer contents are don't-care.

Configuration
REQ-031 The block SHALL, with PROTO_FRAME_CHECKSUM_EN defined, expect a trailing CHK word equal to the XOR of CMD, LEN and all payload words, set status BAD_CHK on mismatch, and append to the response a CHK word equal to the XOR of all preceding response words.
REQ-032 The block SHALL, without PROTO_FRAME_CHECKSUM_EN, have no RX_CHK state, no CHK word in either direction, and never produce BAD_CHK.

Verification
REQ-033 The bench SHALL cover ECHO: rx 01,03,AA,BB,CC -> tx 01,00,03,AA,BB,CC; out_frame_err stays 0.
REQ-034 The bench SHALL cover SUM wrap: rx 02,02,F0,20 -> tx 02,00,01,10.
REQ-035 The bench SHALL cover BAD_LEN with MAX_LEN=16: rx 01,14 plus 20 payload words, all acked -> tx 01,02,00; out_frame_err pulses once.
REQ-036 The bench SHALL cover BAD_CMD and empty payload: rx 7F,00 -> tx 7F,01,00.
REQ-037 The bench SHALL cover timeout with TIMEOUT_CYC=50: rx 01,02,11 then idle 50 cycles -> tx 01,03,00; a following ECHO frame is then processed normally.
REQ-038 The bench SHALL cover checksum (macro on): rx 01,01,55,55 -> tx 01,00,01,55,55; rx 01,01,55,00 -> tx 01,04,00,05.

Source files
------------

// File: rtl/proto_frame_engine.sv
// proto_frame_engine: receives CMD/LEN/payload frames, executes ECHO or SUM, and replies over 4-phase handshakes.
// Define PROTO_FRAME_CHECKSUM_EN to add a trailing XOR CHK word in both directions.
module proto_frame_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [DATA_W-1:0] in_data_rx,
  input  logic              in_data_rx_hsk_req,
  output logic              out_data_rx_hsk_ack,
  output logic [DATA_W-1:0] out_data_tx,
  output logic              out_data_tx_hsk_req,
  input  logic              in_data_tx_hsk_ack,
  output logic              out_rx_enable,
  output logic              out_busy,
  output logic              out_frame_err
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [DATA_W-1:0] ST_OK = '0;
  localparam logic [DATA_W-1:0] ST_BAD_CMD = DATA_W'(1);
  localparam logic [DATA_W-1:0] ST_BAD_LEN = DATA_W'(2);
  localparam logic [DATA_W-1:0] ST_TIMEOUT = DATA_W'(3);
  typedef enum logic [2:0] {
    RX_CMD,
    RX_LEN,
    RX_PAY,
`ifdef PROTO_FRAME_CHECKSUM_EN
    RX_CHK,
`endif
    EXEC,
    TX
  } state_t;
`ifdef PROTO_FRAME_CHECKSUM_EN
  localparam logic [DATA_W-1:0] ST_BAD_CHK = DATA_W'(4);
  localparam state_t PAY_NEXT = RX_CHK;
  localparam logic [8:0] CHK_W = 9'd1;
`else
  localparam state_t PAY_NEXT = EXEC;
  localparam logic [8:0] CHK_W = 9'd0;
`endif
  state_t state_q, state_d;
  logic ack_q, ack_d, tx_req_q, tx_req_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d, cmd_q, cmd_d, sum_q, sum_d;
  logic [DATA_W-1:0] status_q, status_d, tx_chk_q, tx_chk_d, tx_word;
  logic [7:0] len_q, len_d, cnt_q, cnt_d, rlen_q, rlen_d, rx_len;
  logic [8:0] tx_idx_q, tx_idx_d, tx_total;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DATA_W-1:0] buf_q [MAX_LEN];
  logic buf_we, rx_mid, accept, tmo_hit, is_echo, is_sum;
  logic [AW-1:0] wr_idx, rd_idx;
  assign rx_mid = state_q != RX_CMD && state_q != EXEC && state_q != TX;
  assign out_rx_enable = (state_q == RX_CMD || rx_mid) && !ack_q;
  assign accept = out_rx_enable && in_data_rx_hsk_req;
  assign tmo_hit = rx_mid && !in_data_rx_hsk_req && !ack_q && tmo_q == TW'(TIMEOUT_CYC - 1);
  assign out_busy = state_q != RX_CMD;
  assign out_data_rx_hsk_ack = ack_q;
  assign out_data_tx = tx_data_q;
  assign out_data_tx_hsk_req = tx_req_q;
  assign is_echo = cmd_q == DATA_W'(1);
  assign is_sum = cmd_q == DATA_W'(2);
  assign rx_len = 8'(in_data_rx);
  assign wr_idx = AW'(cnt_q);
  assign rd_idx = AW'(tx_idx_q - 9'd3);
  assign tx_total = 9'd3 + 9'(rlen_q) + CHK_W;
  // Response layout: CMD, STATUS, RLEN, data..., then CHK slot when enabled.
  assign tx_word = tx_idx_q == 9'd0 ? cmd_q :
                   tx_idx_q == 9'd1 ? status_q :
                   tx_idx_q == 9'd2 ? DATA_W'(rlen_q) :
                   tx_idx_q < 9'd3 + 9'(rlen_q) ? (is_echo ? buf_q[rd_idx] : sum_q) : tx_chk_q;
`ifdef PROTO_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] rx_chk_q, rx_chk_d;
  always_comb rx_chk_d = !accept ? rx_chk_q : state_q == RX_CMD ? in_data_rx : rx_chk_q ^ in_data_rx;
  always_ff @(posedge in_clk) rx_chk_q <= in_rst ? '0 : rx_chk_d;
`endif
  always_comb begin
    state_d = state_q;
    ack_d = ack_q ? in_data_rx_hsk_req : accept;
    tx_req_d = tx_req_q;
    tx_data_d = tx_data_q;
    cmd_d = cmd_q;
    len_d = len_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    status_d = status_q;
    rlen_d = rlen_q;
    tx_idx_d = tx_idx_q;
    tx_chk_d = tx_chk_q;
    buf_we = 1'b0;
    out_frame_err = 1'b0;
    tmo_d = (accept || !rx_mid) ? '0 : (!in_data_rx_hsk_req && !ack_q) ? tmo_q + TW'(1) : tmo_q;
    case (state_q)
      RX_CMD: if (accept) begin
        cmd_d = in_data_rx;
        sum_d = '0;
        cnt_d = '0;
        status_d = ST_OK;
        state_d = RX_LEN;
      end
      RX_LEN: if (accept) begin
        len_d = rx_len;
        status_d = rx_len > MAX_L ? ST_BAD_LEN : status_q;
        state_d = rx_len == 8'd0 ? PAY_NEXT : RX_PAY;
      end
      RX_PAY: if (accept) begin
        buf_we = len_q <= MAX_L;
        sum_d = sum_q + in_data_rx;
        cnt_d = cnt_q + 8'd1;
        state_d = cnt_q + 8'd1 == len_q ? PAY_NEXT : RX_PAY;
      end
`ifdef PROTO_FRAME_CHECKSUM_EN
      RX_CHK: if (accept) begin
        status_d = (status_q == ST_OK && in_data_rx != rx_chk_q) ? ST_BAD_CHK : status_q;
        state_d = EXEC;
      end
`endif
      EXEC: begin
        status_d = (status_q == ST_OK && !is_echo && !is_sum) ? ST_BAD_CMD : status_q;
        rlen_d = status_d != ST_OK ? 8'd0 : is_echo ? len_q : 8'd1;
        tx_idx_d = '0;
        tx_chk_d = '0;
        state_d = TX;
      end
      TX: begin
        if (tx_req_q && in_data_tx_hsk_ack) begin
          tx_req_d = 1'b0;
          tx_idx_d = tx_idx_q + 9'd1;
          tx_chk_d = tx_chk_q ^ tx_data_q;
        end else if (!tx_req_q && !in_data_tx_hsk_ack) begin
          if (tx_idx_q == tx_total) begin
            state_d = RX_CMD;
            out_frame_err = status_q != ST_OK;
          end else begin
            tx_req_d = 1'b1;
            tx_data_d = tx_word;
          end
        end
      end
      default: state_d = RX_CMD;
    endcase
    if (tmo_hit) begin
      status_d = ST_TIMEOUT;
      state_d = EXEC;
    end
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= RX_CMD;
      ack_q <= 1'b0;
      tx_req_q <= 1'b0;
      tx_data_q <= '0;
      cmd_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      status_q <= ST_OK;
      rlen_q <= '0;
      tx_idx_q <= '0;
      tx_chk_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      tx_req_q <= tx_req_d;
      tx_data_q <= tx_data_d;
      cmd_q <= cmd_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      status_q <= status_d;
      rlen_q <= rlen_d;
      tx_idx_q <= tx_idx_d;
      tx_chk_q <= tx_chk_d;
      tmo_q <= tmo_d;
    end
  end
  always_ff @(posedge in_clk) begin
    if (buf_we) buf_q[wr_idx] <= in_data_rx;
  end
endmodule

// File: tb/tb_proto_frame_engine.sv
// tb_proto_frame_engine: directed frame vectors for proto_frame_engine (MAX_LEN=16, TIMEOUT_CYC=50).
// Expected CHK words are appended when PROTO_FRAME_CHECKSUM_EN is defined.
module tb_proto_frame_engine;
  typedef struct {
    int n_rx;
    int n_tx;
    int err;
    logic [31:0][7:0] rx;
    logic [31:0][7:0] tx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_req = 1'b0;
  logic tx_ack = 1'b0;
  logic out_data_rx_hsk_ack, out_data_tx_hsk_req, out_rx_enable, out_busy, out_frame_err;
  logic [7:0] out_data_tx;
  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  proto_frame_engine #(.DATA_W(8), .MAX_LEN(16), .TIMEOUT_CYC(50)) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_data_rx(rx_data),
    .in_data_rx_hsk_req(rx_req),
    .out_data_rx_hsk_ack(out_data_rx_hsk_ack),
    .out_data_tx(out_data_tx),
    .out_data_tx_hsk_req(out_data_tx_hsk_req),
    .in_data_tx_hsk_ack(tx_ack),
    .out_rx_enable(out_rx_enable),
    .out_busy(out_busy),
    .out_frame_err(out_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int nr, input logic [255:0] r, input int nt, input logic [255:0] t, input int err);
    vec_t v;
    v.rx = '0;
    v.tx = '0;
    v.n_rx = nr;
    v.n_tx = nt;
    v.err = err;
    for (int i = 0; i < nr; i++) v.rx[i] = r[(nr-1-i)*8 +: 8];
    for (int i = 0; i < nt; i++) v.tx[i] = t[(nt-1-i)*8 +: 8];
    return v;
  endfunction

  function automatic vec_t fin(input vec_t v);
`ifdef PROTO_FRAME_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < v.n_rx; i++) x ^= v.rx[i];
    v.rx[v.n_rx] = x;
    v.n_rx++;
    x = '0;
    for (int i = 0; i < v.n_tx; i++) x ^= v.tx[i];
    v.tx[v.n_tx] = x;
    v.n_tx++;
`endif
    return v;
  endfunction

  // Frame-error pulse counter, sampled mid-low-phase after the bench's own negedge drives settle.
  always @(negedge clk) begin
    #2;
    if (out_frame_err) err_pulses++;
  end

  // Tx sink: records each word, acks after a short delay, checks data holds until ack falls.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (out_data_tx_hsk_req && !tx_ack) begin
        w = out_data_tx;
        got.push_back(w);
        check("rx_en_busy_in_tx", 32'({out_rx_enable, out_busy}), 32'd1);
        repeat (2) @(negedge clk);
        tx_ack = 1'b1;
        for (int i = 0; i < 20 && out_data_tx_hsk_req; i++) @(negedge clk);
        check("tx_req_drop", 32'(out_data_tx_hsk_req), 32'd0);
        check("tx_data_stable", 32'(out_data_tx), 32'(w));
        tx_ack = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] w);
    for (int i = 0; i < 500 && !out_rx_enable; i++) @(negedge clk);
    rx_data = w;
    rx_req = 1'b1;
    for (int i = 0; i < 500 && !out_data_rx_hsk_ack; i++) @(negedge clk);
    check("rx_ack", 32'(out_data_rx_hsk_ack), 32'd1);
    rx_req = 1'b0;
    for (int i = 0; i < 500 && out_data_rx_hsk_ack; i++) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input vec_t v, input bit poke);
    int e0;
    e0 = err_pulses;
    got.delete();
    for (int i = 0; i < v.n_rx; i++) send_rx(v.rx[i]);
    if (poke) begin
      for (int i = 0; i < 500 && got.size() == 0; i++) @(negedge clk);
      rx_data = 8'h99;
      rx_req = 1'b1;
      repeat (4) begin
        @(negedge clk);
        check({name, " rx_ignored"}, 32'(out_data_rx_hsk_ack), 32'd0);
      end
      rx_req = 1'b0;
    end
    for (int i = 0; i < 2000 && (got.size() < v.n_tx || out_busy); i++) @(negedge clk);
    @(negedge clk);
    check({name, " count"}, 32'(got.size()), 32'(v.n_tx));
    for (int i = 0; i < v.n_tx; i++)
      check($sformatf("%s w%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(v.tx[i]));
    check({name, " frame_err"}, 32'(err_pulses - e0), 32'(v.err));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ack"}, 32'(out_data_rx_hsk_ack), 32'd0);
    check({name, " tx_req"}, 32'(out_data_tx_hsk_req), 32'd0);
    check({name, " tx_data"}, 32'(out_data_tx), 32'd0);
    check({name, " rx_en"}, 32'(out_rx_enable), 32'd1);
    check({name, " busy"}, 32'(out_busy), 32'd0);
    check({name, " frame_err"}, 32'(out_frame_err), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    vec_t v;
    int nv;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    vecs[0] = fin(mk(5, {8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC}, 6, {8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC}, 0));
    vecs[1] = fin(mk(4, {8'h02, 8'h02, 8'hF0, 8'h20}, 4, {8'h02, 8'h00, 8'h01, 8'h10}, 0));
    vecs[2] = fin(mk(2, {8'h7F, 8'h00}, 3, {8'h7F, 8'h01, 8'h00}, 1));
    vecs[3] = fin(mk(2, {8'h02, 8'h00}, 4, {8'h02, 8'h00, 8'h01, 8'h00}, 0));
    vecs[4] = fin(mk(2, {8'h01, 8'h00}, 3, {8'h01, 8'h00, 8'h00}, 0));
    v = mk(2, {8'h01, 8'h10}, 3, {8'h01, 8'h00, 8'h10}, 0);
    for (int i = 0; i < 16; i++) begin
      v.rx[2+i] = 8'(i * 17 + 3);
      v.tx[3+i] = 8'(i * 17 + 3);
    end
    v.n_rx = 18;
    v.n_tx = 19;
    vecs[5] = fin(v);
    v = mk(2, {8'h01, 8'h14}, 3, {8'h01, 8'h02, 8'h00}, 1);
    for (int i = 0; i < 20; i++) v.rx[2+i] = 8'(8'h30 + i);
    v.n_rx = 22;
    vecs[6] = fin(v);
    v = fin(mk(3, {8'h01, 8'h02, 8'h11}, 3, {8'h01, 8'h03, 8'h00}, 1));
    v.n_rx = 3;
    vecs[7] = v;
    vecs[8] = vecs[0];
    nv = 9;
`ifdef PROTO_FRAME_CHECKSUM_EN
    vecs[9] = mk(4, {8'h01, 8'h01, 8'h55, 8'h55}, 5, {8'h01, 8'h00, 8'h01, 8'h55, 8'h55}, 0);
    vecs[10] = mk(4, {8'h01, 8'h01, 8'h55, 8'h00}, 4, {8'h01, 8'h04, 8'h00, 8'h05}, 1);
    nv = 11;
`endif
    for (int k = 0; k < nv; k++) run_frame($sformatf("vec%0d", k), vecs[k], k == 0);
    got.delete();
    send_rx(8'h01);
    send_rx(8'h03);
    send_rx(8'hAA);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    run_frame("after_reset", vecs[0], 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
